// File: rtl/vec_wb_pkg.sv
// Shared types and helpers for the vector wishbone sequencer.
// State encoding, stream opcodes, error word, address decode.
package vec_wb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INSTR,
    S_LD_OP,
    S_LD_DATA,
    S_ST_OP,
    S_ST_IDX,
    S_ST_WAIT,
    S_ACK,
    S_ERR
  } state_e;

  localparam logic [31:0] VLOAD_OP  = {5'b00000, 27'b0};
  localparam logic [31:0] VSTORE_OP = {5'b00001, 27'b0};
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  // Addresses below the data window wrap to a huge
  // offset, so the single range compare rejects them.
  function automatic state_e decode_req(
    input logic [31:0] adr,
    input logic [31:0] base,
    input logic [31:0] words,
    input logic        we,
    input logic [3:0]  sel
  );
    logic [31:0] off;
    state_e      st;
    off = adr - base - 32'd4;
    st  = S_ERR;
    if (adr == base) begin
      st = we ? S_INSTR : S_ERR;
    end else if (off[1:0] == 2'b00 &&
                 (off >> 2) < words) begin
      if (!we)
        st = S_ST_OP;
      else if (sel == 4'hF)
        st = S_LD_OP;
      else
        st = S_ERR;
    end
    return st;
  endfunction

  function automatic logic [31:0] word_index(
    input logic [31:0] adr,
    input logic [31:0] base
  );
    return (adr - base - 32'd4) >> 2;
  endfunction

endpackage

// File: rtl/vec_wb_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, cleared on clr.
// Ports: clk, rst (sync, high), clr_i, en_i, expired_o.
module vec_wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != LIMIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires on the last permitted cycle so the state
  // is left after exactly TIMEOUT cycles of waiting.
  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/vec_wb_sequencer.sv
// Wishbone slave that sequences host accesses into vector streams.
// Ports: wishbone slave, instruction/load sinks, store source.
module vec_wb_sequencer
  import vec_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] instruction_recv_msg,
  output logic        instruction_recv_val,
  input  logic        instruction_recv_rdy,
  output logic [63:0] load_recv_msg,
  output logic        load_recv_val,
  input  logic        load_recv_rdy,
  input  logic [31:0] store_send_msg,
  input  logic        store_send_val,
  output logic        store_send_rdy
);

  state_e      state_q, state_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] rd_q, rd_d;
  logic        blank_q, blank_d;
  logic        ival_q, ival_d;
  logic [31:0] imsg_q, imsg_d;
  logic        lval_q, lval_d;
  logic [63:0] lmsg_q, lmsg_d;
  logic        srdy_q, srdy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] wdat_q, wdat_d;

  logic wd_en;
  logic wd_clr;
  logic wd_expired;

  assign wd_en = state_q inside {S_INSTR, S_LD_OP,
    S_LD_DATA, S_ST_OP, S_ST_IDX, S_ST_WAIT};
  assign wd_clr = (state_d != state_q);

  vec_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        // blank_q masks the cycle after a termination
        if (!blank_q && wbs_cyc_i && wbs_stb_i) begin
          state_d = decode_req(wbs_adr_i, BASE_ADDR,
            32'(NUM_WORDS), wbs_we_i, wbs_sel_i);
          dat_d = wbs_dat_i;
          idx_d = word_index(wbs_adr_i, BASE_ADDR);
          rd_d  = '0;
        end
      end
      S_INSTR:
        if (instruction_recv_rdy) state_d = S_ACK;
      S_LD_OP:
        if (instruction_recv_rdy) state_d = S_LD_DATA;
      S_LD_DATA:
        if (load_recv_rdy) state_d = S_ACK;
      S_ST_OP:
        if (instruction_recv_rdy) state_d = S_ST_IDX;
      S_ST_IDX:
        if (load_recv_rdy) state_d = S_ST_WAIT;
      S_ST_WAIT:
        if (store_send_val) begin
          rd_d    = store_send_msg;
          state_d = S_ACK;
        end
      S_ACK, S_ERR:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    // A handshake on the final cycle still wins.
    if (wd_en && state_d == state_q && wd_expired)
      state_d = S_ERR;

    blank_d = (state_q == S_ACK) || (state_q == S_ERR);

    // Outputs follow the state being entered.
    ival_d = state_d inside {S_INSTR, S_LD_OP, S_ST_OP};
    imsg_d = '0;
    unique case (1'b1)
      (state_d == S_INSTR): imsg_d = dat_d;
      (state_d == S_LD_OP): imsg_d = VLOAD_OP;
      (state_d == S_ST_OP): imsg_d = VSTORE_OP;
      default:              imsg_d = '0;
    endcase
    lval_d = state_d inside {S_LD_DATA, S_ST_IDX};
    lmsg_d = '0;
    unique case (1'b1)
      (state_d == S_LD_DATA): lmsg_d = {idx_d, dat_d};
      (state_d == S_ST_IDX):  lmsg_d = {idx_d, 32'h0};
      default:                lmsg_d = '0;
    endcase
    srdy_d = (state_d == S_ST_WAIT);
    ack_d  = (state_d == S_ACK);
    err_d  = (state_d == S_ERR);
    wdat_d = '0;
    unique case (1'b1)
      ack_d:   wdat_d = rd_d;
      err_d:   wdat_d = ERR_DATA;
      default: wdat_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      dat_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      blank_q <= 1'b0;
      ival_q  <= 1'b0;
      imsg_q  <= '0;
      lval_q  <= 1'b0;
      lmsg_q  <= '0;
      srdy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      blank_q <= blank_d;
      ival_q  <= ival_d;
      imsg_q  <= imsg_d;
      lval_q  <= lval_d;
      lmsg_q  <= lmsg_d;
      srdy_q  <= srdy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      wdat_q  <= wdat_d;
    end
  end

  assign instruction_recv_val = ival_q;
  assign instruction_recv_msg = imsg_q;
  assign load_recv_val        = lval_q;
  assign load_recv_msg        = lmsg_q;
  assign store_send_rdy       = srdy_q;
  assign wbs_ack_o            = ack_q;
  assign wbs_err_o            = err_q;
  assign wbs_dat_o            = wdat_q;

endmodule

// File: tb/tb_vec_wb_sequencer.sv
// Bench for vec_wb_sequencer: step-queue model checked every cycle,
// plus directed accesses with hand-computed literal expectations.
module tb_vec_wb_sequencer;

  localparam int TO = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int K_I = 0;
  localparam int K_L = 1;
  localparam int K_W = 2;
  localparam int K_A = 3;
  localparam int K_E = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        ack, err;
  logic [31:0] dato;
  logic [31:0] imsg;
  logic        ival;
  logic        irdy = 1'b1;
  logic [63:0] lmsg;
  logic        lval;
  logic        lrdy = 1'b1;
  logic [31:0] smsg = '0;
  logic        sval = 1'b0;
  logic        srdy;

  vec_wb_sequencer #(.TIMEOUT(TO)) dut (
    .wb_clk_i            (clk),
    .wb_rst_i            (rst),
    .wbs_stb_i           (stb),
    .wbs_cyc_i           (cyc),
    .wbs_we_i            (we),
    .wbs_sel_i           (sel),
    .wbs_adr_i           (adr),
    .wbs_dat_i           (dat),
    .wbs_ack_o           (ack),
    .wbs_err_o           (err),
    .wbs_dat_o           (dato),
    .instruction_recv_msg(imsg),
    .instruction_recv_val(ival),
    .instruction_recv_rdy(irdy),
    .load_recv_msg       (lmsg),
    .load_recv_val       (lval),
    .load_recv_rdy       (lrdy),
    .store_send_msg      (smsg),
    .store_send_val      (sval),
    .store_send_rdy      (srdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: each access is a queue of expected steps.
  typedef struct {
    int          kind;
    logic [63:0] msg;
  } step_t;

  step_t       mq[$];
  int          m_cnt = 0;
  bit          m_blank = 1'b0;
  logic [31:0] m_rd = '0;

  function automatic step_t mk(input int k,
                               input logic [63:0] m);
    step_t s;
    s.kind = k;
    s.msg  = m;
    return s;
  endfunction

  // Observation log for the directed checks.
  logic [31:0] ib[$];
  logic [63:0] lb[$];
  int          n_ack = 0;
  int          n_err = 0;
  int          term_cyc = -1;
  logic [31:0] term_dat = '0;

  always @(negedge clk) begin : mon
    logic        e_iv, e_lv, e_sr, e_ak, e_er;
    logic [31:0] e_im, e_dat;
    logic [63:0] e_lm;
    logic [31:0] a;
    bit          fired;
    e_iv = 0; e_lv = 0; e_sr = 0; e_ak = 0; e_er = 0;
    e_im = '0; e_dat = '0; e_lm = '0;
    if (mq.size() != 0) begin
      case (mq[0].kind)
        K_I: begin e_iv = 1; e_im = mq[0].msg[31:0]; end
        K_L: begin e_lv = 1; e_lm = mq[0].msg; end
        K_W: e_sr = 1;
        K_A: begin e_ak = 1; e_dat = m_rd; end
        default: begin e_er = 1; e_dat = 32'hDEAD_BEEF; end
      endcase
    end
    if (cmp_en) begin
      check("instr_val", ival, e_iv);
      check("instr_msg", imsg, e_im);
      check("load_val", lval, e_lv);
      check("load_msg", lmsg, e_lm);
      check("store_rdy", srdy, e_sr);
      check("ack", ack, e_ak);
      check("err", err, e_er);
      check("dat_o", dato, e_dat);
      if (ival && irdy) ib.push_back(imsg);
      if (lval && lrdy) lb.push_back(lmsg);
      if (ack) begin n_ack++; term_cyc = cyc_n; term_dat = dato; end
      if (err) begin n_err++; term_cyc = cyc_n; term_dat = dato; end
    end
    // advance the model across the coming edge
    if (rst) begin
      mq.delete();
      m_cnt = 0;
      m_blank = 0;
      m_rd = '0;
    end else if (mq.size() == 0) begin
      if (!m_blank && cyc && stb) begin
        a = adr;
        m_rd = '0;
        m_cnt = 0;
        if (a == BASE) begin
          if (we) begin
            mq.push_back(mk(K_I, {32'h0, dat}));
            mq.push_back(mk(K_A, 64'h0));
          end else
            mq.push_back(mk(K_E, 64'h0));
        end else if (a >= BASE + 32'd4 && a[1:0] == 2'b00 &&
                     ((a - BASE - 32'd4) >> 2) < 32) begin
          if (!we) begin
            mq.push_back(mk(K_I, 64'h0800_0000));
            mq.push_back(mk(K_L, {(a - BASE - 32'd4) >> 2, 32'h0}));
            mq.push_back(mk(K_W, 64'h0));
            mq.push_back(mk(K_A, 64'h0));
          end else if (sel == 4'hF) begin
            mq.push_back(mk(K_I, 64'h0));
            mq.push_back(mk(K_L, {(a - BASE - 32'd4) >> 2, dat}));
            mq.push_back(mk(K_A, 64'h0));
          end else
            mq.push_back(mk(K_E, 64'h0));
        end else
          mq.push_back(mk(K_E, 64'h0));
      end
      m_blank = 0;
    end else if (mq[0].kind == K_A || mq[0].kind == K_E) begin
      void'(mq.pop_front());
      m_blank = 1;
      m_cnt = 0;
    end else begin
      fired = (mq[0].kind == K_I && irdy) ||
              (mq[0].kind == K_L && lrdy) ||
              (mq[0].kind == K_W && sval);
      if (fired) begin
        if (mq[0].kind == K_W) m_rd = smsg;
        void'(mq.pop_front());
        m_cnt = 0;
      end else if (m_cnt + 1 >= TO) begin
        mq.delete();
        mq.push_back(mk(K_E, 64'h0));
        m_cnt = 0;
      end else
        m_cnt++;
    end
  end

  task automatic clear_log();
    ib.delete();
    lb.delete();
    n_ack = 0;
    n_err = 0;
    term_cyc = -1;
    term_dat = '0;
  endtask

  // Classic cycle: stb held until ack/err. sv_delay raises
  // store_send_val that many cycles after stb (-1: never).
  task automatic access(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic w,
                        input logic [3:0] s,
                        input int sv_delay,
                        input logic [31:0] sv_msg,
                        input bit hold,
                        output int t0);
    bit done;
    int k;
    clear_log();
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; sel = s; adr = a; dat = d;
    t0 = cyc_n;
    if (sv_delay == 0) begin sval = 1; smsg = sv_msg; end
    done = 0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      if (ack || err) done = 1;
      @(posedge clk); #1;
      k++;
      if (k == sv_delay) begin sval = 1; smsg = sv_msg; end
    end
    if (hold) begin @(posedge clk); #1; end
    cyc = 0; stb = 0; we = 0; sel = 0; adr = '0; dat = '0;
    sval = 0; smsg = '0;
    check("access_terminated", done, 1);
  endtask

  logic [31:0] e_adr [5] = '{32'h3000_0000, 32'h3000_0004,
    32'h3000_0084, 32'h3000_0006, 32'h2FFF_FFFC};
  logic        e_we  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0]  e_sel [5] = '{4'hF, 4'h3, 4'hF, 4'hF, 4'hF};

  initial begin
    int  t;
    int  k;
    bit  seen;
    repeat (3) @(posedge clk);
    #1 cmp_en = 1;
    @(negedge clk);
    check("rst_ival", ival, 0);
    check("rst_lval", lval, 0);
    check("rst_srdy", srdy, 0);
    check("rst_ack_err", {ack, err}, 0);
    check("rst_msgs", {imsg, lmsg}, 0);
    check("rst_dat", dato, 0);
    @(posedge clk); #1 rst = 0;

    // instruction write, stb held into the blank cycle
    access(BASE, 32'h1234_5678, 1, 4'hF, -1, 0, 1, t);
    check("t1_beats", ib.size(), 1);
    check("t1_msg", ib[0], 32'h1234_5678);
    check("t1_lat", term_cyc - t, 2);
    check("t1_one_ack", n_ack, 1);

    // data write, index 2
    access(32'h3000_000C, 32'hCAFE_0001, 1, 4'hF, -1, 0, 0, t);
    check("t2_ibeats", ib.size(), 1);
    check("t2_op", ib[0], 32'h0);
    check("t2_lbeats", lb.size(), 1);
    check("t2_lmsg", lb[0], {32'd2, 32'hCAFE_0001});
    check("t2_lat", term_cyc - t, 3);

    // data read, index 1, store data arrives late
    access(32'h3000_0008, 0, 0, 4'hF, 9, 32'hA5A5_A5A5, 0, t);
    check("t3_op", ib[0], 32'h0800_0000);
    check("t3_lmsg", lb[0], {32'd1, 32'h0});
    check("t3_dat", term_dat, 32'hA5A5_A5A5);
    check("t3_lat", term_cyc - t, 10);
    check("t3_ack", n_ack, 1);

    // minimum-latency read of the last word
    access(32'h3000_0080, 0, 0, 4'hF, 0, 32'h0BAD_F00D, 0, t);
    check("t3b_lmsg", lb[0], {32'd31, 32'h0});
    check("t3b_dat", term_dat, 32'h0BAD_F00D);
    check("t3b_lat", term_cyc - t, 4);

    // instruction sink stalled: watchdog
    irdy = 0;
    access(BASE, 32'h1111_2222, 1, 4'hF, -1, 0, 0, t);
    irdy = 1;
    check("t4_err", n_err, 1);
    check("t4_dat", term_dat, 32'hDEAD_BEEF);
    check("t4_lat", term_cyc - t, TO + 1);
    check("t4_nobeat", ib.size(), 0);

    // decode errors
    for (int i = 0; i < 5; i++) begin
      access(e_adr[i], 32'h5555_5555, e_we[i], e_sel[i],
             -1, 0, 0, t);
      check("t5_err", n_err, 1);
      check("t5_lat", term_cyc - t, 1);
      check("t5_quiet", ib.size() + lb.size(), 0);
      check("t5_dat", term_dat, 32'hDEAD_BEEF);
    end

    // read with no store data: times out in the wait
    access(32'h3000_0004, 0, 0, 4'hF, -1, 0, 0, t);
    check("t6_err", n_err, 1);
    check("t6_lat", term_cyc - t, TO + 3);
    check("t6_lmsg", lb[0], 64'h0);

    // reset while stalled in the load-data beat
    clear_log();
    lrdy = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; sel = 4'hF;
    adr = 32'h3000_0010; dat = 32'h7777_8888;
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (lval) seen = 1; else k++;
    end
    check("t7_reach", seen, 1);
    check("t7_lmsg", lmsg, {32'd3, 32'h7777_8888});
    @(posedge clk); #1;
    rst = 1; cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    rst = 0; lrdy = 1;
    @(negedge clk);
    check("t7_vals", {ival, lval, srdy, ack, err}, 0);
    access(BASE, 32'h0BEE_F001, 1, 4'hF, -1, 0, 0, t);
    check("t7_after", ib[0], 32'h0BEE_F001);
    check("t7_lat", term_cyc - t, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
